vram_console: RTL and testbench

VRAM_CONSOLE -- requirements
Module: vram_console

---
 rtl/vram_console.sv | 147 ++++++++++++++
 tb/tb_vram_console.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/vram_console.sv
// Character console that turns a byte stream into VRAM cell writes.
// It handles cursor movement, autowrap, line clearing and a full screen clear.
module vram_console #(
  parameter bit WIDE           = 1'b1,
  parameter bit RGB            = 1'b0,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [7:0]  attr,
  output logic [11:0] waddr,
  output logic [15:0] wdata,
  output logic        we,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy
);

  localparam logic [11:0] COLS  = WIDE ? 12'd40 : 12'd80;
  localparam logic [11:0] CELLS = 12'd30 * COLS;

  typedef enum logic [1:0] {IDLE, CLR_LINE, CLR_SCREEN} state_t;

  state_t      state, state_nxt;
  logic [6:0]  cursor_x_nxt;
  logic [4:0]  cursor_y_nxt;
  logic [11:0] clr_addr, clr_addr_nxt;
  logic [11:0] clr_end, clr_end_nxt;
  logic        init_pending;
  logic        we_nxt;
  logic [11:0] waddr_nxt;
  logic [15:0] wdata_nxt;
  logic        accept;
  logic [7:0]  attr_eff;
  logic [11:0] cell_addr;
  logic [4:0]  next_y;
  logic [11:0] next_row_base;

  // The power-up clear is launched from IDLE on the first edge, so input is held off until then.
  assign in_ready      = (state == IDLE) && !init_pending;
  assign busy          = (state != IDLE);
  assign accept        = in_valid && in_ready;
  assign attr_eff      = RGB ? attr : 8'h00;
  assign cell_addr     = {7'd0, cursor_y} * COLS + {5'd0, cursor_x};
  assign next_y        = (cursor_y == 5'd29) ? 5'd0 : cursor_y + 5'd1;
  assign next_row_base = {7'd0, next_y} * COLS;

  always_comb begin
    state_nxt    = state;
    cursor_x_nxt = cursor_x;
    cursor_y_nxt = cursor_y;
    clr_addr_nxt = clr_addr;
    clr_end_nxt  = clr_end;
    we_nxt       = 1'b0;
    waddr_nxt    = waddr;
    wdata_nxt    = wdata;

    case (state)
      IDLE: begin
        if (init_pending) begin
          state_nxt    = CLR_SCREEN;
          clr_addr_nxt = 12'd0;
          clr_end_nxt  = CELLS - 12'd1;
        end else if (accept) begin
          if ((in_data >= 8'h20) && (in_data <= 8'h7E)) begin
            we_nxt    = 1'b1;
            waddr_nxt = cell_addr;
            wdata_nxt = {attr_eff, in_data};
            if ({5'd0, cursor_x} == COLS - 12'd1) begin
              cursor_x_nxt = 7'd0;
              cursor_y_nxt = next_y;
              state_nxt    = CLR_LINE;
              clr_addr_nxt = next_row_base;
              clr_end_nxt  = next_row_base + COLS - 12'd1;
            end else begin
              cursor_x_nxt = cursor_x + 7'd1;
            end
          end else begin
            case (in_data)
              8'h0D: cursor_x_nxt = 7'd0;
              8'h0A: begin
                cursor_x_nxt = 7'd0;
                cursor_y_nxt = next_y;
                state_nxt    = CLR_LINE;
                clr_addr_nxt = next_row_base;
                clr_end_nxt  = next_row_base + COLS - 12'd1;
              end
              8'h08: begin
                if (cursor_x != 7'd0) cursor_x_nxt = cursor_x - 7'd1;
              end
              8'h0C: begin
                cursor_x_nxt = 7'd0;
                cursor_y_nxt = 5'd0;
                state_nxt    = CLR_SCREEN;
                clr_addr_nxt = 12'd0;
                clr_end_nxt  = CELLS - 12'd1;
              end
              default: ;
            endcase
          end
        end
      end

      // Both clear flavours walk clr_addr up to clr_end, one space per cycle.
      CLR_LINE, CLR_SCREEN: begin
        we_nxt    = 1'b1;
        waddr_nxt = clr_addr;
        wdata_nxt = {attr_eff, 8'h20};
        if (clr_addr == clr_end) begin
          state_nxt = IDLE;
        end else begin
          clr_addr_nxt = clr_addr + 12'd1;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cursor_x     <= 7'd0;
      cursor_y     <= 5'd0;
      clr_addr     <= 12'd0;
      clr_end      <= 12'd0;
      init_pending <= CLEAR_ON_RESET;
      we           <= 1'b0;
      waddr        <= 12'd0;
      wdata        <= 16'd0;
    end else begin
      state        <= state_nxt;
      cursor_x     <= cursor_x_nxt;
      cursor_y     <= cursor_y_nxt;
      clr_addr     <= clr_addr_nxt;
      clr_end      <= clr_end_nxt;
      init_pending <= 1'b0;
      we           <= we_nxt;
      waddr        <= waddr_nxt;
      wdata        <= wdata_nxt;
    end
  end

endmodule

// File: tb/tb_vram_console.sv
// Directed bench for vram_console (40-column grid, attribute byte enabled, clear on reset).
module tb_vram_console;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [7:0]  attr;
  logic [11:0] waddr;
  logic [15:0] wdata;
  logic        we;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy;

  int total = 0;
  int bad   = 0;

  vram_console #(.WIDE(1'b1), .RGB(1'b1), .CLEAR_ON_RESET(1'b1)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .attr     (attr),
    .waddr    (waddr),
    .wdata    (wdata),
    .we       (we),
    .cursor_x (cursor_x),
    .cursor_y (cursor_y),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Offers one byte, waits (bounded) for in_ready, and returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] b);
    int t;
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Follows a burst of n consecutive space writes starting at base after the current cycle.
  task automatic checkBurst(input string tag, input int n, input logic [11:0] base, input logic [15:0] data);
    int t;
    int hits;
    int ready_high;
    @(posedge clk); #1;
    t = 0;
    while (!we && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    hits = 0;
    ready_high = 0;
    for (int i = 0; i < n; i++) begin
      if (we === 1'b1 && waddr === base + 12'(i) && wdata === data) hits++;
      if (i < n - 1) begin
        if (in_ready !== 1'b0) ready_high++;
        @(posedge clk); #1;
      end
    end
    checkOutput({tag, "_hits"}, hits, n);
    checkOutput({tag, "_ready_low"}, ready_high, 0);
    checkOutput({tag, "_ready_after"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    checkOutput({tag, "_we_end"}, {31'd0, we}, 32'd0);
  endtask

  initial begin
    int t;
    int writes;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    attr     = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_we", {31'd0, we}, 32'd0);
    checkOutput("rst_waddr", {20'd0, waddr}, 32'd0);
    checkOutput("rst_wdata", {16'd0, wdata}, 32'd0);
    checkOutput("rst_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("rst_cy", {27'd0, cursor_y}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);

    $display("[TB] power-up clear");
    rst_n = 1'b1;
    checkBurst("clr_reset", 1200, 12'd0, 16'h0020);
    checkOutput("post_clr_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("post_clr_cy", {27'd0, cursor_y}, 32'd0);

    $display("[TB] single printable write at (3,2)");
    applyStimulus(8'h0A);
    applyStimulus(8'h0A);
    applyStimulus(8'h61);
    applyStimulus(8'h62);
    applyStimulus(8'h63);
    checkOutput("pos_cx", {25'd0, cursor_x}, 32'd3);
    attr = 8'h71;
    applyStimulus(8'h41);
    checkOutput("a_we", {31'd0, we}, 32'd1);
    checkOutput("a_waddr", {20'd0, waddr}, 32'd83);
    checkOutput("a_wdata", {16'd0, wdata}, 32'h7141);
    checkOutput("a_cx", {25'd0, cursor_x}, 32'd4);
    checkOutput("a_cy", {27'd0, cursor_y}, 32'd2);
    @(posedge clk); #1;
    checkOutput("a_we_pulse", {31'd0, we}, 32'd0);

    $display("[TB] back-to-back CR, BEL, B");
    in_valid = 1'b1;
    in_data  = 8'h0D;
    checkOutput("b2b_ready0", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    checkOutput("cr_we", {31'd0, we}, 32'd0);
    checkOutput("cr_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("b2b_ready1", {31'd0, in_ready}, 32'd1);
    in_data = 8'h07;
    @(posedge clk); #1;
    checkOutput("bel_we", {31'd0, we}, 32'd0);
    checkOutput("bel_cy", {27'd0, cursor_y}, 32'd2);
    checkOutput("b2b_ready2", {31'd0, in_ready}, 32'd1);
    in_data = 8'h42;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("b_we", {31'd0, we}, 32'd1);
    checkOutput("b_waddr", {20'd0, waddr}, 32'd80);
    checkOutput("b_wdata", {16'd0, wdata}, 32'h7142);
    checkOutput("b_cx", {25'd0, cursor_x}, 32'd1);

    $display("[TB] backspace");
    applyStimulus(8'h08);
    checkOutput("bs1_we", {31'd0, we}, 32'd0);
    checkOutput("bs1_cx", {25'd0, cursor_x}, 32'd0);
    applyStimulus(8'h08);
    checkOutput("bs0_we", {31'd0, we}, 32'd0);
    checkOutput("bs0_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("bs0_cy", {27'd0, cursor_y}, 32'd2);

    $display("[TB] form feed then autowrap on row 0");
    applyStimulus(8'h0C);
    checkOutput("ff_busy", {31'd0, busy}, 32'd1);
    checkOutput("ff_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("ff_cy", {27'd0, cursor_y}, 32'd0);
    checkBurst("clr_ff", 1200, 12'd0, 16'h7120);
    for (int i = 0; i < 39; i++) applyStimulus(8'h41);
    checkOutput("row0_cx", {25'd0, cursor_x}, 32'd39);
    applyStimulus(8'h5A);
    checkOutput("z_we", {31'd0, we}, 32'd1);
    checkOutput("z_waddr", {20'd0, waddr}, 32'd39);
    checkOutput("z_wdata", {16'd0, wdata}, 32'h715A);
    checkOutput("z_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("z_cy", {27'd0, cursor_y}, 32'd1);
    checkOutput("z_ready", {31'd0, in_ready}, 32'd0);
    checkBurst("clr_wrap", 40, 12'd40, 16'h7120);

    $display("[TB] line feed wrap from row 29");
    for (int i = 0; i < 28; i++) applyStimulus(8'h0A);
    checkOutput("row29_cy", {27'd0, cursor_y}, 32'd29);
    applyStimulus(8'h0A);
    checkOutput("lfw_cx", {25'd0, cursor_x}, 32'd0);
    checkOutput("lfw_cy", {27'd0, cursor_y}, 32'd0);
    checkBurst("clr_lfw", 40, 12'd0, 16'h7120);

    $display("[TB] reset during screen clear");
    applyStimulus(8'h0C);
    t = 0;
    while (!(we === 1'b1 && waddr === 12'd500) && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("abort_reach500", {20'd0, waddr}, 32'd500);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_we", {31'd0, we}, 32'd0);
    checkOutput("abort_waddr", {20'd0, waddr}, 32'd0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (we !== 1'b0) writes++;
    end
    checkOutput("abort_no_writes", writes, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("restart_we", {31'd0, we}, 32'd1);
    checkOutput("restart_waddr", {20'd0, waddr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
